div3_serial: RTL and testbench
==============================

DIV3_SERIAL -- requirements
Module: div3_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the dividend and quotient width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only when ready=1.
REQ-005 SHALL have port X  input  WIDTH  unsigned dividend; captured on the accepting edge.
REQ-006 SHALL have port ready  output  1  high only in IDLE, meaning the block can accept start.
REQ-007 SHALL have port done  output  1  one-cycle pulse; Z and R are valid during the pulse.
REQ-008 SHALL have port Z  output  WIDTH  quotient floor(X/3).
REQ-009 SHALL have port R  output  2  remainder X mod 3, binary-encoded (0, 1 or 2; value 3 is never driven).

Function
REQ-010 SHALL implement states IDLE, SHIFT and DONE, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-011 SHALL, in IDLE with start=1 at edge k, capture X into a shift register, clear the remainder register and the counter, and enter SHIFT.
REQ-012 SHALL, in SHIFT, process one dividend bit per edge, MSB first, over edges k+1 through k+WIDTH.
REQ-013 SHALL, for each processed bit b with current remainder r, form t = 2r + b, shift the quotient bit (t >= 3) into Z from the LSB side, and set r to t - 3 when t >= 3, otherwise to t.
REQ-014 SHALL, after edge k+WIDTH, present the final Z and R, enter DONE and assert done for exactly that one cycle.
REQ-015 SHALL return from DONE to IDLE on the next edge (k+WIDTH+1), after which ready=1.
REQ-016 SHALL hold Z and R stable from DONE until the next accepted start.
REQ-017 SHALL ignore start while in SHIFT or DONE, with no effect on state or operand.
REQ-018 SHALL, in IDLE with start=0, leave every register unchanged.
REQ-019 SHALL keep the fixed latency at WIDTH+1 cycles from accept to done for every value of X, including 0 and 2^WIDTH-1.
REQ-020 SHALL allow back-to-back operation: a start held high is accepted on the first IDLE edge, giving a throughput of one division per WIDTH+2 cycles.

Reset
REQ-021 SHALL, while rst=1, asynchronously force state=IDLE, counter=0, Z=0, R=0, done=0 and ready=1.
REQ-022 SHALL abandon any in-flight division when rst is asserted mid-operation, with no done pulse for that division.
REQ-023 SHALL ignore a start that is coincident with rst, and SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro DIV3_SERIAL_ABORT_EN is defined, add port abort (input, 1 bit).
REQ-025 SHALL, with DIV3_SERIAL_ABORT_EN defined, make abort=1 in SHIFT send the block to IDLE on that edge without a done pulse, leaving Z and R at their partial values.
REQ-026 SHALL, with DIV3_SERIAL_ABORT_EN defined, give abort priority over start, and give abort no effect in IDLE or DONE.
REQ-027 SHALL, without DIV3_SERIAL_ABORT_EN, omit the abort port and its logic entirely.

Verification
REQ-028 SHALL cover: WIDTH=4, X=9, start at edge k -> done in the cycle after edge k+4, Z=3, R=0; ready=1 after edge k+5.
REQ-029 SHALL cover: WIDTH=4, X=14 -> Z=4, R=2; X=0 -> Z=0, R=0; X=15 -> Z=5, R=0; each with latency 5.
REQ-030 SHALL cover: WIDTH=4, start pulsed again two cycles after accepting X=7 with X=12 -> result is Z=2, R=1 and the second request is ignored.
REQ-031 SHALL cover: rst asserted at edge k+2 of a division of X=11 -> immediate IDLE with Z=0, R=0 and no done; then X=11 -> Z=3, R=2.
REQ-032 SHALL cover: WIDTH=8, exhaustive X = 0..255 against a floor(X/3) and X mod 3 model -> X=255 gives Z=85, R=0 and X=254 gives Z=84, R=2.
REQ-033 SHALL cover, with DIV3_SERIAL_ABORT_EN defined: abort at edge k+2 of X=13 -> IDLE, no done, ready=1; a following X=13 -> Z=4, R=1.

Source files
------------

// File: rtl/div3_serial.sv
// ============================================================================
//  Module      : div3_serial
//  Description : Serial restoring divide-by-3. Processes one dividend bit per
//                clock, MSB first, producing quotient floor(X/3) and remainder
//                X mod 3 after WIDTH shift cycles, then pulses done for one
//                cycle before returning to IDLE.
//                Optional feature macro: DIV3_SERIAL_ABORT_EN (adds an abort
//                input that cancels an in-flight division).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div3_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DIV3_SERIAL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic [1:0]       R
);

    // Counter wide enough to hold 0..WIDTH
    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] x_q,     x_d;
    logic [WIDTH-1:0] z_q,     z_d;
    logic [1:0]       r_q,     r_d;

    logic [2:0]       w_t;       // 2r + b, at most 5 since r <= 2
    logic [2:0]       w_t_sub;   // t - 3, meaningful only when t >= 3
    logic             w_qbit;

    // One remainder step on the current MSB of the operand shift register
    assign w_t     = {r_q, 1'b0} + {2'b00, x_q[WIDTH-1]};
    assign w_qbit  = (w_t >= 3'd3);
    assign w_t_sub = w_t - 3'd3;

    // Next-state logic for the FSM and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        z_d     = z_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = X;
                    r_d     = 2'd0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef DIV3_SERIAL_ABORT_EN
                // Abort leaves Z/R at whatever partial values they hold
                if (abort) begin
                    state_d = IDLE;
                end else
`endif
                begin
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                    z_d   = {z_q[WIDTH-2:0], w_qbit};
                    r_d   = w_qbit ? w_t_sub[1:0] : w_t[1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            z_q     <= '0;
            r_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            z_q     <= z_d;
            r_q     <= r_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign Z     = z_q;
    assign R     = r_q;

endmodule

`default_nettype wire

// File: tb/tb_div3_serial.sv
// ============================================================================
//  Module      : tb_div3_serial
//  Description : Self-checking bench for div3_serial. Drives a WIDTH=4 and a
//                WIDTH=8 instance; expected quotient/remainder/accept-cycle are
//                queued when a request is accepted and popped on done.
//                Abort scenarios are built when DIV3_SERIAL_ABORT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div3_serial;

    typedef struct {
        logic [7:0] z;
        logic [1:0] r;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] x4;
    logic [7:0] x8;
    logic       ready4, done4, ready8, done8;
    logic [3:0] z4;
    logic [7:0] z8;
    logic [1:0] r4, r8;
`ifdef DIV3_SERIAL_ABORT_EN
    logic       abort4;
    logic       abort8;
`endif

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic chk_rdy4 = 1'b0;
    logic chk_rdy8 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div3_serial #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
`ifdef DIV3_SERIAL_ABORT_EN
        .abort (abort4),
`endif
        .start (start4),
        .X     (x4),
        .ready (ready4),
        .done  (done4),
        .Z     (z4),
        .R     (r4)
    );

    div3_serial #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
`ifdef DIV3_SERIAL_ABORT_EN
        .abort (abort8),
`endif
        .start (start8),
        .X     (x8),
        .ready (ready8),
        .done  (done8),
        .Z     (z8),
        .R     (r8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: compare each done pulse against the oldest queued request
    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_rdy4) begin
            chk("ready_after_done4", int'(ready4), 1);
            chk("done_one_cycle4", int'(done4), 0);
        end
        if (chk_rdy8) begin
            chk("ready_after_done8", int'(ready8), 1);
        end
        chk_rdy4 = 1'b0;
        chk_rdy8 = 1'b0;
        if (done4) begin
            if (q4.size() == 0) begin
                chk("spurious_done4", 1, 0);
            end else begin
                e = q4.pop_front();
                chk("z4", int'(z4), int'(e.z));
                chk("r4", int'(r4), int'(e.r));
                chk("latency4", cyc - e.acc, 4);
                chk_rdy4 = 1'b1;
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("z8", int'(z8), int'(e.z));
                chk("r8", int'(r8), int'(e.r));
                chk("latency8", cyc - e.acc, 8);
                chk_rdy8 = 1'b1;
            end
        end
    end

    task automatic push4(input logic [3:0] x, input int acc);
        exp_t e;
        e.z   = 8'(x / 4'd3);
        e.r   = 2'(x % 4'd3);
        e.acc = acc;
        q4.push_back(e);
    endtask

    task automatic push8(input logic [7:0] x, input int acc);
        exp_t e;
        e.z   = x / 8'd3;
        e.r   = 2'(x % 8'd3);
        e.acc = acc;
        q8.push_back(e);
    endtask

    // Wait (bounded) until all queued results are out and the block is idle
    task automatic wait4();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q4.size() != 0 || !ready4) && n < 40);
        if (n >= 40) chk("timeout4", 0, 1);
    endtask

    task automatic wait8();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q8.size() != 0 || !ready8) && n < 40);
        if (n >= 40) chk("timeout8", 0, 1);
    endtask

    task automatic run4(input logic [3:0] x);
        wait4();
        x4     = x;
        start4 = 1'b1;
        push4(x, cyc + 1);
        @(negedge clk);
        start4 = 1'b0;
        chk("busy4", int'(ready4), 0);
        wait4();
        repeat (2) @(negedge clk);
        chk("hold_z4", int'(z4), int'(x / 4'd3));
        chk("hold_r4", int'(r4), int'(x % 4'd3));
    endtask

    task automatic run8(input logic [7:0] x);
        wait8();
        x8     = x;
        start8 = 1'b1;
        push8(x, cyc + 1);
        @(negedge clk);
        start8 = 1'b0;
        wait8();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst    = 1'b1;
        start4 = 1'b0;
        start8 = 1'b0;
        x4     = '0;
        x8     = '0;
`ifdef DIV3_SERIAL_ABORT_EN
        abort4 = 1'b0;
        abort8 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready4", int'(ready4), 1);
        chk("rst_done4",  int'(done4),  0);
        chk("rst_z4",     int'(z4),     0);
        chk("rst_r4",     int'(r4),     0);
        chk("rst_ready8", int'(ready8), 1);
        chk("rst_z8",     int'(z8),     0);
        rst = 1'b0;

        // Basic results, including operand extremes
        run4(4'd9);
        run4(4'd14);
        run4(4'd0);
        run4(4'd15);

        // A second start during SHIFT is ignored
        wait4();
        x4     = 4'd7;
        start4 = 1'b1;
        push4(4'd7, cyc + 1);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        x4     = 4'd12;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait4();
        repeat (4) @(negedge clk);
        chk("ignored_start_idle4", int'(ready4), 1);

        // Reset mid-division, with a start coincident with reset
        wait4();
        x4     = 4'd11;
        start4 = 1'b1;
        push4(4'd11, cyc + 1);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        q4.delete();
        start4 = 1'b1;
        #1;
        chk("midrst_ready4", int'(ready4), 1);
        chk("midrst_done4",  int'(done4),  0);
        chk("midrst_z4",     int'(z4),     0);
        chk("midrst_r4",     int'(r4),     0);
        @(negedge clk);
        chk("rst_start_ignored4", int'(ready4), 1);
        rst = 1'b0;
        push4(4'd11, cyc + 1);
        @(negedge clk);
        start4 = 1'b0;
        chk("accept_after_rst4", int'(ready4), 0);
        wait4();

        // Back-to-back: start held high, next accept WIDTH+2 cycles later
        x4     = 4'd5;
        start4 = 1'b1;
        push4(4'd5, cyc + 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done4 && n < 20);
        if (n >= 20) chk("b2b_timeout4", 0, 1);
        x4 = 4'd10;
        push4(4'd10, cyc + 2);
        @(negedge clk);
        chk("b2b_ready4", int'(ready4), 1);
        @(negedge clk);
        start4 = 1'b0;
        chk("b2b_busy4", int'(ready4), 0);
        wait4();

`ifdef DIV3_SERIAL_ABORT_EN
        // Abort mid-division: no done, back to IDLE, then a clean rerun
        wait4();
        x4     = 4'd13;
        start4 = 1'b1;
        push4(4'd13, cyc + 1);
        @(negedge clk);
        start4 = 1'b0;
        abort4 = 1'b1;
        start4 = 1'b1;
        q4.delete();
        @(negedge clk);
        abort4 = 1'b0;
        start4 = 1'b0;
        chk("abort_ready4", int'(ready4), 1);
        chk("abort_done4",  int'(done4),  0);
        repeat (6) @(negedge clk);
        run4(4'd13);
`endif

        // Exhaustive WIDTH=8 sweep
        for (int x = 0; x < 256; x++) begin
            run8(8'(x));
        end

        repeat (4) @(negedge clk);
        chk("sb4_empty", q4.size(), 0);
        chk("sb8_empty", q8.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
